// File: rtl/dominant_orientation_scanner_if.sv
//------------------------------------------------------------------------------
// Module   : dominant_orientation_scanner_if
// Purpose  : Valid/ready peak-record channel from the orientation scanner.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dominant_orientation_scanner_if #(
   parameter int IDX_W = 6,
   parameter int BIN_W = 16
);
   logic             opeak_valid;
   logic             opeak_ready;
   logic [IDX_W-1:0] opeak_index;
   logic [BIN_W-1:0] opeak_value;
   logic             opeak_primary;

   modport master (
      output opeak_valid,
      output opeak_index,
      output opeak_value,
      output opeak_primary,
      input  opeak_ready
   );

   modport slave (
      input  opeak_valid,
      input  opeak_index,
      input  opeak_value,
      input  opeak_primary,
      output opeak_ready
   );
endinterface

`default_nettype wire

// File: rtl/dominant_orientation_scanner.sv
//------------------------------------------------------------------------------
// Module   : dominant_orientation_scanner
// Purpose  : Snapshots a 36-bin orientation histogram, finds the dominant bin
//            and streams the dominant plus strong secondary local peaks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dominant_orientation_scanner #(
   parameter int NBINS    = 36,
   parameter int BIN_W    = 16,
   parameter int IDX_W    = 6,
   parameter int PEAK_NUM = 205
) (
   input  wire logic                   iclk,
   input  wire logic                   ireset,
   input  wire logic                   istart,
   input  wire logic [NBINS*BIN_W-1:0] ibins,
   output logic                        obusy,
   output logic                        odone,
   output logic [IDX_W-1:0]            opeak_count,
   dominant_orientation_scanner_if.master opeak
);

   localparam int PROD_W = BIN_W + 8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_MAX    = 3'd2;
   localparam logic [2:0] S_THRESH = 3'd3;
   localparam logic [2:0] S_PEAK   = 3'd4;
   localparam logic [2:0] S_DRAIN  = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   localparam logic [IDX_W-1:0] c_LAST  = IDX_W'(NBINS - 1);
   localparam logic [IDX_W-1:0] c_NBINS = IDX_W'(NBINS);

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [BIN_W-1:0] r_bins [NBINS];
   logic [IDX_W-1:0] r_i;
   logic [BIN_W-1:0] r_max;
   logic [IDX_W-1:0] r_maxidx;
   logic [BIN_W-1:0] r_thr;
   logic             r_valid;
   logic [IDX_W-1:0] r_index;
   logic [BIN_W-1:0] r_value;
   logic             r_primary;
   logic [IDX_W-1:0] r_count;

   logic [IDX_W-1:0] w_il;
   logic [IDX_W-1:0] w_ir;
   logic [BIN_W-1:0] w_cur;
   logic [BIN_W-1:0] w_left;
   logic [BIN_W-1:0] w_right;
   logic             w_is_max;
   logic             w_qual;
   logic             w_xfer;
   logic             w_stall;
   logic             w_load;
   logic             w_last;

   // Circular neighbours: bin 0 sees bin NBINS-1 on its left and vice versa.
   assign w_il    = (r_i == '0)     ? c_LAST : r_i - IDX_W'(1);
   assign w_ir    = (r_i == c_LAST) ? '0     : r_i + IDX_W'(1);
   assign w_cur   = r_bins[r_i];
   assign w_left  = r_bins[w_il];
   assign w_right = r_bins[w_ir];
   assign w_last  = (r_i == c_LAST);

   assign w_is_max = (r_i == r_maxidx);
   assign w_qual   = w_is_max ||
                     ((w_cur >= r_thr) && (w_cur > w_left) &&
                      (w_cur >= w_right) && (w_cur != '0));
   assign w_xfer   = r_valid && opeak.opeak_ready;
   assign w_stall  = w_qual && r_valid && !opeak.opeak_ready;
   assign w_load   = (r_state == S_PEAK) && w_qual && !w_stall;

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (istart) w_next = S_LOAD;
         S_LOAD:   w_next = S_MAX;
         S_MAX:    if (w_last) w_next = S_THRESH;
         S_THRESH: w_next = S_PEAK;
         S_PEAK:   if (!w_stall && w_last) w_next = S_DRAIN;
         S_DRAIN:  if (!r_valid || w_xfer) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      obusy = (r_state != S_IDLE);
      odone = (r_state == S_DONE);
   end

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         for (int k = 0; k < NBINS; k++) begin
            r_bins[k] <= '0;
         end
         r_i       <= '0;
         r_max     <= '0;
         r_maxidx  <= '0;
         r_thr     <= '0;
         r_valid   <= 1'b0;
         r_index   <= '0;
         r_value   <= '0;
         r_primary <= 1'b0;
         r_count   <= '0;
      end else begin
         case (r_state)
            S_LOAD: begin
               for (int k = 0; k < NBINS; k++) begin
                  r_bins[k] <= ibins[k*BIN_W +: BIN_W];
               end
               r_i      <= '0;
               r_max    <= '0;
               r_maxidx <= '0;
               r_count  <= '0;
            end
            S_MAX: begin
               // Strict compare keeps the lowest index on ties.
               if (w_cur > r_max) begin
                  r_max    <= w_cur;
                  r_maxidx <= r_i;
               end
               r_i <= w_last ? '0 : r_i + IDX_W'(1);
            end
            S_THRESH: begin
               r_thr <= BIN_W'((PROD_W'(r_max) * PROD_W'(PEAK_NUM)) >> 8);
               r_i   <= '0;
            end
            S_PEAK: begin
               if (!w_stall) begin
                  r_i <= w_last ? '0 : r_i + IDX_W'(1);
                  if (w_qual) begin
                     r_index   <= r_i;
                     r_value   <= w_cur;
                     r_primary <= w_is_max;
                     if (r_count != c_NBINS) begin
                        r_count <= r_count + IDX_W'(1);
                     end
                  end
               end
            end
            default: ;
         endcase

         if (w_load) begin
            r_valid <= 1'b1;
         end else if (w_xfer) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign opeak.opeak_valid   = r_valid;
   assign opeak.opeak_index   = r_index;
   assign opeak.opeak_value   = r_value;
   assign opeak.opeak_primary = r_primary;
   assign opeak_count         = r_count;

endmodule

`default_nettype wire

// File: tb/tb_dominant_orientation_scanner.sv
//------------------------------------------------------------------------------
// Module   : tb_dominant_orientation_scanner
// Purpose  : Directed self-checking bench for dominant_orientation_scanner.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dominant_orientation_scanner;

   localparam int NB = 36;
   localparam int BW = 16;
   localparam int IW = 6;

   logic                 iclk;
   logic                 ireset;
   logic                 istart;
   logic [NB*BW-1:0]     ibins;
   logic                 obusy;
   logic                 odone;
   logic [IW-1:0]        opeak_count;

   dominant_orientation_scanner_if #(.IDX_W(IW), .BIN_W(BW)) pif ();

   dominant_orientation_scanner #(
      .NBINS(NB), .BIN_W(BW), .IDX_W(IW), .PEAK_NUM(205)
   ) u_dut (
      .iclk        (iclk),
      .ireset      (ireset),
      .istart      (istart),
      .ibins       (ibins),
      .obusy       (obusy),
      .odone       (odone),
      .opeak_count (opeak_count),
      .opeak       (pif)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          t0       = 0;
   int          first_valid = -1;
   int          done_cnt = 0;
   logic [22:0] rec_q [$];
   logic        hold_prev = 1'b0;
   logic [23:0] prev_snap = '0;
   logic [NB*BW-1:0] b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge iclk) cyc++;

   // Observes the channel mid-cycle: a record seen valid&&ready here transfers on the next edge.
   always @(negedge iclk) begin
      #2;
      if (!ireset) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev)
            chk("hold_stable", {8'b0, pif.opeak_valid, pif.opeak_primary,
                                pif.opeak_index, pif.opeak_value}, {8'b0, prev_snap});
         if (pif.opeak_valid && first_valid < 0) first_valid = cyc;
         if (pif.opeak_valid && pif.opeak_ready)
            rec_q.push_back({pif.opeak_primary, pif.opeak_index, pif.opeak_value});
         hold_prev = pif.opeak_valid && !pif.opeak_ready;
         prev_snap = {pif.opeak_valid, pif.opeak_primary, pif.opeak_index, pif.opeak_value};
         if (odone) done_cnt++;
      end
   end

   function automatic logic [22:0] rec(input logic p, input int idx, input int val);
      return {p, IW'(idx), BW'(val)};
   endfunction

   task automatic start_scan(input logic [NB*BW-1:0] bv);
      @(negedge iclk);
      ibins       = bv;
      istart      = 1'b1;
      rec_q.delete();
      done_cnt    = 0;
      first_valid = -1;
      @(negedge iclk);
      istart = 1'b0;
      t0     = cyc;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (done_cnt == 0 && n < 500) begin
         @(negedge iclk);
         n++;
      end
      if (done_cnt == 0) chk({tag, "_timeout"}, 0, 1);
      repeat (6) @(negedge iclk);
      #3;
   endtask

   task automatic check_result(input string tag, input int n, input logic [22:0] e0,
                               input logic [22:0] e1, input int cnt);
      logic [22:0] e [2];
      e[0] = e0;
      e[1] = e1;
      chk({tag, "_nrec"}, rec_q.size(), n);
      for (int k = 0; k < n; k++) begin
         if (k < rec_q.size()) chk($sformatf("%s_rec%0d", tag, k), {9'b0, rec_q[k]}, {9'b0, e[k]});
      end
      chk({tag, "_count"}, {26'b0, opeak_count}, cnt);
      chk({tag, "_ndone"}, done_cnt, 1);
      chk({tag, "_idle"}, {31'b0, obusy}, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},  {31'b0, obusy}, 0);
      chk({tag, "_done"},  {31'b0, odone}, 0);
      chk({tag, "_valid"}, {31'b0, pif.opeak_valid}, 0);
      chk({tag, "_count"}, {26'b0, opeak_count}, 0);
      chk({tag, "_index"}, {26'b0, pif.opeak_index}, 0);
      chk({tag, "_value"}, {16'b0, pif.opeak_value}, 0);
      chk({tag, "_prim"},  {31'b0, pif.opeak_primary}, 0);
   endtask

   initial begin
      ireset = 1'b0;
      istart = 1'b0;
      ibins  = '0;
      pif.opeak_ready = 1'b1;
      repeat (3) @(negedge iclk);
      #1;
      check_reset_outputs("rst");
      @(negedge iclk);
      ireset = 1'b1;

      // T1: single bin, first valid 39 cycles for bin 0 plus 7 for bin 7
      b = '0; b[7*BW +: BW] = 16'd100;
      start_scan(b);
      wait_done("t1");
      check_result("t1", 1, rec(1'b1, 7, 100), '0, 1);
      chk("t1_latency", first_valid - t0, 46);

      // T2: thr = 1000*205>>8 = 800; bin 20 is a secondary peak, bin 21 is below thr
      for (int k = 0; k < NB; k++) b[k*BW +: BW] = 16'd10;
      b[3*BW +: BW] = 16'd1000; b[20*BW +: BW] = 16'd850; b[21*BW +: BW] = 16'd500;
      start_scan(b);
      wait_done("t2");
      check_result("t2", 2, rec(1'b1, 3, 1000), rec(1'b0, 20, 850), 2);

      // T3a: wrap and tie, primary stays at the lowest index
      b = '0; b[0 +: BW] = 16'd500; b[35*BW +: BW] = 16'd500;
      start_scan(b);
      wait_done("t3a");
      check_result("t3a", 2, rec(1'b1, 0, 500), rec(1'b0, 35, 500), 2);

      // T3b: all zero, primary at bin 0 at the minimum latency
      b = '0;
      start_scan(b);
      wait_done("t3b");
      check_result("t3b", 1, rec(1'b1, 0, 0), '0, 1);
      chk("t3b_latency", first_valid - t0, 39);

      // T4: backpressure for 10 cycles after first valid
      for (int k = 0; k < NB; k++) b[k*BW +: BW] = 16'd10;
      b[3*BW +: BW] = 16'd1000; b[20*BW +: BW] = 16'd850; b[21*BW +: BW] = 16'd500;
      pif.opeak_ready = 1'b0;
      start_scan(b);
      begin
         int n;
         n = 0;
         while (!pif.opeak_valid && n < 200) begin
            @(negedge iclk);
            n++;
         end
         chk("t4_valid_seen", {31'b0, pif.opeak_valid}, 1);
         repeat (10) @(negedge iclk);
         #1;
         chk("t4_held_idx", {26'b0, pif.opeak_index}, 3);
         chk("t4_held_val", {16'b0, pif.opeak_value}, 1000);
         pif.opeak_ready = 1'b1;
      end
      wait_done("t4");
      check_result("t4", 2, rec(1'b1, 3, 1000), rec(1'b0, 20, 850), 2);

      // T5a: ibins cleared and istart re-pulsed during MAX; snapshot must win
      b = '0; b[7*BW +: BW] = 16'd100;
      start_scan(b);
      @(negedge iclk);
      ibins  = '0;
      istart = 1'b1;
      @(negedge iclk);
      istart = 1'b0;
      #1;
      chk("t5a_busy", {31'b0, obusy}, 1);
      wait_done("t5a");
      repeat (60) @(negedge iclk);
      #3;
      check_result("t5a", 1, rec(1'b1, 7, 100), '0, 1);

      // T5b: reset asserted during PEAK aborts the scan
      for (int k = 0; k < NB; k++) b[k*BW +: BW] = 16'd10;
      b[3*BW +: BW] = 16'd1000; b[20*BW +: BW] = 16'd850; b[21*BW +: BW] = 16'd500;
      start_scan(b);
      repeat (45) @(negedge iclk);
      #1;
      chk("t5b_busy_pre", {31'b0, obusy}, 1);
      ireset = 1'b0;
      #1;
      check_reset_outputs("t5b_rst");
      repeat (3) @(negedge iclk);
      ireset   = 1'b1;
      done_cnt = 0;
      repeat (60) @(negedge iclk);
      #3;
      chk("t5b_no_done", done_cnt, 0);
      chk("t5b_idle", {31'b0, obusy}, 0);

      b = '0;
      start_scan(b);
      wait_done("t5c");
      check_result("t5c", 1, rec(1'b1, 0, 0), '0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
